m_frame_sequencer: RTL and testbench

Per-frame scheduler for the game's render loop. It divides the system clock into frame ticks, issues one game-logic step every LOGIC_DIV frames, and enables `m_renderer` once per frame until it reports `finished`. It sits between the top-level game FSM (`start`/`pause`) and the logic and renderer blocks. It supervises both handshakes with a watchdog and reports overruns.

---
 rtl/m_frame_sequencer_pkg.sv | 28 ++
 rtl/m_frame_sequencer_tick_divider.sv | 50 +++++
 rtl/m_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_m_frame_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// m_frame_sequencer_pkg
// Shared definitions for the frame sequencer slice: default timing
// parameters, the sequencer state encoding and a counter-width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package m_frame_sequencer_pkg;

    // 50 MHz system clock divided down to a 60 Hz frame tick.
    localparam int DEF_TICK_DIV       = 833333;
    localparam int DEF_LOGIC_DIV      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 65536;

    // Encoding is visible on dbg_state, so the values are fixed.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_LOGIC  = 2'd2,
        S_RENDER = 2'd3
    } seq_state_t;

    // Width of a counter that runs 0..n-1; never narrower than one bit so
    // a divide-by-one still has a legal register.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/m_frame_sequencer_tick_divider.sv
// ---------------------------------------------------------------------------
// m_tick_divider
// Divides the system clock into a single-cycle frame tick strobe.
// Ports:
//   clock  in  system clock
//   resetn in  asynchronous active-low reset
//   run    in  counter runs while high, is held at zero while low
//   tick   out one-cycle strobe when the counter sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module m_tick_divider
    import m_frame_sequencer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    output logic tick
);

    localparam int              CW       = cntWidth(TICK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter restarts from zero whenever the sequencer leaves idle, so the
    // first tick lands a full frame period after the run begins.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/m_frame_sequencer.sv
// ---------------------------------------------------------------------------
// m_frame_sequencer
// Per-frame scheduler for the render loop: issues a game-logic step every
// LOGIC_DIV frame ticks, enables the renderer once per frame until it
// reports finished, and watches both handshakes with a watchdog.
// Ports:
//   clock, resetn     system clock, asynchronous active-low reset
//   start, pause      level controls from the game FSM
//   logic_step        one-cycle request to the logic block
//   logic_done        one-cycle completion pulse from the logic block
//   render_enable     enable to the renderer (combinational gate)
//   render_finished   renderer finished flag
//   frame_count       completed renders, wraps at 2^16
//   overrun, timeout  sticky error flags
//   busy              high in S_LOGIC or S_RENDER
//   dbg_state         current state encoding
// ---------------------------------------------------------------------------
module m_frame_sequencer
    import m_frame_sequencer_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int LOGIC_DIV      = DEF_LOGIC_DIV,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        pause,
    output logic        logic_step,
    input  logic        logic_done,
    output logic        render_enable,
    input  logic        render_finished,
    output logic [15:0] frame_count,
    output logic        overrun,
    output logic        timeout,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int            LW         = cntWidth(LOGIC_DIV);
    localparam int            WW         = cntWidth(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] LOGIC_LAST = LW'(LOGIC_DIV - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [LW-1:0] logic_cnt_q, logic_cnt_d, logic_cnt_inc;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          ren_q, ren_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          logic_step_q, logic_step_d;
    logic          busy_q, busy_d;
    logic          tick;

    m_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clock  (clock),
        .resetn (resetn),
        .run    (state_q != S_IDLE),
        .tick   (tick)
    );

    // Logic-step phase counter wraps at LOGIC_DIV-1; it advances on every
    // tick, including ticks dropped as overruns and ticks while paused.
    assign logic_cnt_inc = (logic_cnt_q == LOGIC_LAST) ? '0 : logic_cnt_q + 1'b1;

    // Next-state logic. The state case handles normal sequencing; the start
    // check at the end overrides it because losing start beats every other
    // event, while sticky flags and the frame count are left untouched.
    always_comb begin
        state_d       = state_q;
        logic_cnt_d   = logic_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        ren_d         = ren_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        logic_step_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                logic_cnt_d = '0;
                wd_cnt_d    = '0;
                ren_d       = 1'b0;
                if (start) begin
                    state_d       = S_WAIT;
                    frame_count_d = '0;
                    overrun_d     = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    logic_cnt_d = logic_cnt_inc;
                    wd_cnt_d    = '0;
                    if ((logic_cnt_q == LOGIC_LAST) && !pause) begin
                        state_d      = S_LOGIC;
                        logic_step_d = 1'b1;
                    end else begin
                        state_d = S_RENDER;
                        ren_d   = 1'b1;
                    end
                end
            end
            S_LOGIC: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (tick) begin
                    overrun_d   = 1'b1;
                    logic_cnt_d = logic_cnt_inc;
                end
                // Completion is checked before expiry so a late done wins.
                if (logic_done) begin
                    state_d  = S_RENDER;
                    ren_d    = 1'b1;
                    wd_cnt_d = '0;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d   = S_WAIT;
                    timeout_d = 1'b1;
                    wd_cnt_d  = '0;
                end
            end
            S_RENDER: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (tick) begin
                    overrun_d   = 1'b1;
                    logic_cnt_d = logic_cnt_inc;
                end
                if (render_finished) begin
                    state_d       = S_WAIT;
                    ren_d         = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    wd_cnt_d      = '0;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d   = S_WAIT;
                    ren_d     = 1'b0;
                    timeout_d = 1'b1;
                    wd_cnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!start) begin
            state_d       = S_IDLE;
            ren_d         = 1'b0;
            logic_step_d  = 1'b0;
            logic_cnt_d   = '0;
            wd_cnt_d      = '0;
            frame_count_d = frame_count_q;
            overrun_d     = overrun_q;
            timeout_d     = timeout_q;
        end

        busy_d = (state_d == S_LOGIC) || (state_d == S_RENDER);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            logic_cnt_q   <= '0;
            wd_cnt_q      <= '0;
            ren_q         <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            logic_step_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            logic_cnt_q   <= logic_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            ren_q         <= ren_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            logic_step_q  <= logic_step_d;
            busy_q        <= busy_d;
        end
    end

    // The enable drops in the same cycle finished rises, so the renderer
    // never sees a stray enable cycle that would restart its erase pass.
    assign render_enable = ren_q & ~render_finished;
    assign logic_step    = logic_step_q;
    assign frame_count   = frame_count_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_m_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_m_frame_sequencer
// Directed bench for m_frame_sequencer. Instance A uses TICK_DIV=100,
// LOGIC_DIV=2, TIMEOUT_CYCLES=50; instance B uses TIMEOUT_CYCLES=200 for the
// slow-renderer case. Cycle numbers are counted from the clock edge that
// takes the sequencer out of idle (cycle 1 is the first cycle in S_WAIT),
// so tick n falls in cycle 100*n.
// ---------------------------------------------------------------------------
module tb_m_frame_sequencer;

    logic        clock;
    logic        resetn;

    logic        startA, pauseA, logicDoneA, renderFinishedA;
    logic        logicStepA, renderEnableA, overrunA, timeoutA, busyA;
    logic [15:0] frameCountA;
    logic [1:0]  dbgStateA;

    logic        startB, pauseB, logicDoneB, renderFinishedB;
    logic        logicStepB, renderEnableB, overrunB, timeoutB, busyB;
    logic [15:0] frameCountB;
    logic [1:0]  dbgStateB;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int renDelayA  = 20;
    int renDelayB  = 150;
    int doneDelay  = 5;
    int stepsA     = 0;
    int startsA    = 0;
    int stepsB     = 0;
    int renCntA    = 0;
    int renCntB    = 0;
    int logicCntA  = 0;
    int logicCntB  = 0;

    m_frame_sequencer #(
        .TICK_DIV       (100),
        .LOGIC_DIV      (2),
        .TIMEOUT_CYCLES (50)
    ) dutA (
        .clock           (clock),
        .resetn          (resetn),
        .start           (startA),
        .pause           (pauseA),
        .logic_step      (logicStepA),
        .logic_done      (logicDoneA),
        .render_enable   (renderEnableA),
        .render_finished (renderFinishedA),
        .frame_count     (frameCountA),
        .overrun         (overrunA),
        .timeout         (timeoutA),
        .busy            (busyA),
        .dbg_state       (dbgStateA)
    );

    m_frame_sequencer #(
        .TICK_DIV       (100),
        .LOGIC_DIV      (2),
        .TIMEOUT_CYCLES (200)
    ) dutB (
        .clock           (clock),
        .resetn          (resetn),
        .start           (startB),
        .pause           (pauseB),
        .logic_step      (logicStepB),
        .logic_done      (logicDoneB),
        .render_enable   (renderEnableB),
        .render_finished (renderFinishedB),
        .frame_count     (frameCountB),
        .overrun         (overrunB),
        .timeout         (timeoutB),
        .busy            (busyB),
        .dbg_state       (dbgStateB)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Renderer and logic-block models. They act 1 time unit after each
    // rising edge: the renderer pulses finished after renDelay enabled
    // cycles (0 = never finishes), the logic block pulses done doneDelay
    // cycles after it sees logic_step.
    initial begin
        logic enA, enB;
        renderFinishedA = 1'b0;
        renderFinishedB = 1'b0;
        logicDoneA      = 1'b0;
        logicDoneB      = 1'b0;
        enA             = 1'b0;
        enB             = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (renderFinishedA) begin
                renderFinishedA = 1'b0;
                renCntA = 0;
            end else if (renderEnableA) begin
                if (!enA) startsA++;
                renCntA++;
                if (renDelayA != 0 && renCntA == renDelayA) begin
                    renderFinishedA = 1'b1;
                    renCntA = 0;
                end
            end else begin
                renCntA = 0;
            end
            enA = renderEnableA;

            if (renderFinishedB) begin
                renderFinishedB = 1'b0;
                renCntB = 0;
            end else if (renderEnableB) begin
                renCntB++;
                if (renDelayB != 0 && renCntB == renDelayB) begin
                    renderFinishedB = 1'b1;
                    renCntB = 0;
                end
            end else begin
                renCntB = 0;
            end
            enB = renderEnableB;

            if (logicDoneA) logicDoneA = 1'b0;
            if (logicCntA > 0) begin
                logicCntA--;
                if (logicCntA == 0) logicDoneA = 1'b1;
            end
            if (logicStepA) begin
                stepsA++;
                logicCntA = doneDelay;
            end

            if (logicDoneB) logicDoneB = 1'b0;
            if (logicCntB > 0) begin
                logicCntB--;
                if (logicCntB == 0) logicDoneB = 1'b1;
            end
            if (logicStepB) begin
                stepsB++;
                logicCntB = doneDelay;
            end
        end
    end

    task automatic applyStimulus(input bit selB, input logic st, input logic pa);
        if (selB) begin
            startB = st;
            pauseB = pa;
        end else begin
            startA = st;
            pauseA = pa;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic gotoCycle(input int k);
        while (cyc < k) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        int baseSteps;
        int baseStarts;

        resetn = 1'b1;
        startA = 1'b0;
        pauseA = 1'b0;
        startB = 1'b0;
        pauseB = 1'b0;
        #2 resetn = 1'b0;
        @(negedge clock);
        checkOutput("rst_state",   dbgStateA,     0);
        checkOutput("rst_enable",  renderEnableA, 0);
        checkOutput("rst_step",    logicStepA,    0);
        checkOutput("rst_frames",  frameCountA,   0);
        checkOutput("rst_overrun", overrunA,      0);
        checkOutput("rst_timeout", timeoutA,      0);
        checkOutput("rst_busy",    busyA,         0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("idle_hold", dbgStateA, 0);

        // Nominal sequencing: renders on every tick, logic on even ticks.
        $display("[TB] nominal sequencing");
        baseSteps  = stepsA;
        baseStarts = startsA;
        applyStimulus(0, 1'b1, 1'b0);
        cyc = 0;
        gotoCycle(1);
        checkOutput("nom_wait_entry", dbgStateA,   1);
        checkOutput("nom_wait_busy",  busyA,       0);
        gotoCycle(100);
        checkOutput("nom_pre_tick_en", renderEnableA, 0);
        gotoCycle(101);
        checkOutput("nom_t1_enable", renderEnableA, 1);
        checkOutput("nom_t1_state",  dbgStateA,     3);
        checkOutput("nom_t1_busy",   busyA,         1);
        checkOutput("nom_t1_step",   logicStepA,    0);
        gotoCycle(120);
        checkOutput("gate_same_cycle", renderEnableA, 0);
        checkOutput("gate_state",      dbgStateA,     3);
        checkOutput("gate_frames",     frameCountA,   0);
        gotoCycle(121);
        checkOutput("fin_state",  dbgStateA,     1);
        checkOutput("fin_frames", frameCountA,   1);
        checkOutput("fin_enable", renderEnableA, 0);
        gotoCycle(199);
        checkOutput("idle_until_tick", renderEnableA, 0);
        checkOutput("no_step_t1",      stepsA - baseSteps, 0);
        gotoCycle(200);
        checkOutput("t2_step_early", logicStepA, 0);
        gotoCycle(201);
        checkOutput("t2_step",       logicStepA, 1);
        checkOutput("t2_state",      dbgStateA,  2);
        gotoCycle(202);
        checkOutput("t2_step_width", logicStepA, 0);
        gotoCycle(207);
        checkOutput("done_to_enable", renderEnableA, 1);
        checkOutput("done_state",     dbgStateA,     3);
        gotoCycle(401);
        checkOutput("t4_step", logicStepA, 1);
        gotoCycle(650);
        checkOutput("nom_frames",  frameCountA,          6);
        checkOutput("nom_steps",   stepsA - baseSteps,   3);
        checkOutput("nom_renders", startsA - baseStarts, 6);
        checkOutput("nom_overrun", overrunA, 0);
        checkOutput("nom_timeout", timeoutA, 0);

        // Start removal from S_WAIT keeps the frame count; restart clears it.
        applyStimulus(0, 1'b0, 1'b1);
        gotoCycle(651);
        checkOutput("stop_state",  dbgStateA,   0);
        checkOutput("stop_frames", frameCountA, 6);

        // Pause across ticks 1-4, released before tick 5.
        $display("[TB] pause");
        baseSteps = stepsA;
        applyStimulus(0, 1'b1, 1'b1);
        cyc = 0;
        gotoCycle(1);
        checkOutput("restart_frames", frameCountA, 0);
        checkOutput("restart_state",  dbgStateA,   1);
        gotoCycle(450);
        checkOutput("pause_steps",  stepsA - baseSteps, 0);
        checkOutput("pause_frames", frameCountA,        4);
        applyStimulus(0, 1'b1, 1'b0);
        gotoCycle(501);
        checkOutput("t5_no_step",  logicStepA, 0);
        checkOutput("t5_render",   dbgStateA,  3);
        gotoCycle(601);
        checkOutput("t6_step", logicStepA, 1);
        gotoCycle(650);
        checkOutput("pause_frames_t6", frameCountA, 6);

        // Watchdog: renderer never finishes from tick 7 on.
        $display("[TB] watchdog");
        renDelayA = 0;
        gotoCycle(750);
        checkOutput("wd_before",        timeoutA,      0);
        checkOutput("wd_before_enable", renderEnableA, 1);
        gotoCycle(751);
        checkOutput("wd_timeout", timeoutA,      1);
        checkOutput("wd_enable",  renderEnableA, 0);
        checkOutput("wd_state",   dbgStateA,     1);
        checkOutput("wd_frames",  frameCountA,   6);
        gotoCycle(807);
        checkOutput("wd_rerender",        renderEnableA, 1);
        checkOutput("wd_rerender_frames", frameCountA,   6);

        // Abort mid-render on tick 9.
        $display("[TB] abort and reset");
        gotoCycle(910);
        checkOutput("abort_pre_enable", renderEnableA, 1);
        applyStimulus(0, 1'b0, 1'b0);
        gotoCycle(911);
        checkOutput("abort_state",   dbgStateA,     0);
        checkOutput("abort_enable",  renderEnableA, 0);
        checkOutput("abort_timeout", timeoutA,      1);
        checkOutput("abort_frames",  frameCountA,   6);
        checkOutput("abort_busy",    busyA,         0);

        renDelayA = 20;
        applyStimulus(0, 1'b1, 1'b0);
        cyc = 0;
        gotoCycle(1);
        checkOutput("clear_timeout", timeoutA,    0);
        checkOutput("clear_frames",  frameCountA, 0);
        gotoCycle(121);
        checkOutput("rst_pre_frames", frameCountA, 1);
        gotoCycle(150);
        renDelayA = 0;
        gotoCycle(210);
        checkOutput("rst_pre_enable", renderEnableA, 1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_state",  dbgStateA,     0);
        checkOutput("async_enable", renderEnableA, 0);
        checkOutput("async_frames", frameCountA,   0);
        checkOutput("async_busy",   busyA,         0);
        @(negedge clock);
        applyStimulus(0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(negedge clock);

        // Slow renderer (150 cycles) on instance B: every second tick
        // lands inside S_RENDER and is dropped.
        $display("[TB] overrun");
        baseSteps = stepsB;
        applyStimulus(1, 1'b1, 1'b0);
        cyc = 0;
        gotoCycle(199);
        checkOutput("ov_before", overrunB,  0);
        checkOutput("ov_state",  dbgStateB, 3);
        gotoCycle(201);
        checkOutput("ov_set",    overrunB,      1);
        checkOutput("ov_enable", renderEnableB, 1);
        checkOutput("ov_busy",   busyB,         1);
        gotoCycle(251);
        checkOutput("ov_frames_1", frameCountB, 1);
        checkOutput("ov_wait",     dbgStateB,   1);
        gotoCycle(301);
        checkOutput("ov_t3_render", renderEnableB, 1);
        gotoCycle(551);
        checkOutput("ov_frames_2", frameCountB,        2);
        checkOutput("ov_steps",    stepsB - baseSteps, 0);
        checkOutput("ov_timeout",  timeoutB,           0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
